// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scan driver with frame-synchronous double-buffered display data
//   in : clk, rst_n (async, active low), load, value[4N] (nibble per digit), dp[N], blank[N]
//   out: busy (staged data pending), ack (commit pulse), frame_start (index wrapped to 0),
//        digit_idx[IW], an[N] (active low, one-hot-low), seg[7] {g..a} (active low), dp_n
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int PRESCALE = 100000,
  parameter int GUARD = 4,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2(PRESCALE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic                    busy,
  output logic                    ack,
  output logic                    frame_start,
  output logic [IW-1:0]           digit_idx,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
  logic busy_q, busy_d, ack_q, ack_d, fs_q, fs_d, dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic tick, last, commit, accept;
  logic [3:0] nib;
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction
  always_comb begin
    tick = cnt_q == CW'(PRESCALE - 1);
    last = idx_q == IW'(NUM_DIGITS - 1);
    // staged data only moves to the active set on the frame wrap, so a frame is never mixed
    commit = tick && last && busy_q;
    accept = load && !busy_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? (last ? '0 : idx_q + 1'b1) : idx_q;
    fs_d = tick && last;
    ack_d = commit;
    busy_d = commit ? 1'b0 : (accept | busy_q);
    stg_val_d = accept ? value : stg_val_q;
    stg_dp_d = accept ? dp : stg_dp_q;
    stg_blank_d = accept ? blank : stg_blank_q;
    act_val_d = commit ? stg_val_q : act_val_q;
    act_dp_d = commit ? stg_dp_q : act_dp_q;
    act_blank_d = commit ? stg_blank_q : act_blank_q;
    nib = act_val_q[{idx_q, 2'b00} +: 4];
    // anodes stay off for the first GUARD cycles of each slot to hide segment transitions
    an_d = (cnt_q < CW'(GUARD) || act_blank_q[idx_q]) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = hex_seg(nib);
    dp_n_d = ~act_dp_q[idx_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      stg_val_q <= '0;
      stg_dp_q <= '0;
      stg_blank_q <= '0;
      act_val_q <= '0;
      act_dp_q <= '0;
      act_blank_q <= '0;
      busy_q <= 1'b0;
      ack_q <= 1'b0;
      fs_q <= 1'b0;
      an_q <= '1;
      seg_q <= 7'h7F;
      dp_n_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      stg_val_q <= stg_val_d;
      stg_dp_q <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      act_val_q <= act_val_d;
      act_dp_q <= act_dp_d;
      act_blank_q <= act_blank_d;
      busy_q <= busy_d;
      ack_q <= ack_d;
      fs_q <= fs_d;
      an_q <= an_d;
      seg_q <= seg_d;
      dp_n_q <= dp_n_d;
    end
  end
  assign busy = busy_q;
  assign ack = ack_q;
  assign frame_start = fs_q;
  assign digit_idx = idx_q;
  assign an = an_q;
  assign seg = seg_q;
  assign dp_n = dp_n_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for the scan driver at NUM_DIGITS=8, PRESCALE=4, GUARD=1
module tb_seg7_scan_driver;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [31:0] value = '0;
  logic [7:0] dp = '0, blank = '0;
  logic busy, ack, frame_start, dp_n;
  logic [2:0] digit_idx;
  logic [7:0] an;
  logic [6:0] seg;
  int total = 0, passed = 0;
  typedef struct {logic [31:0] v; logic [7:0] d; logic [7:0] b;} frm_t;
  typedef struct {int at; frm_t f;} req_t;
  frm_t exp_q[$];
  req_t req_q[$];
  frm_t disp = '{32'h0, 8'h0, 8'h0};
  bit busy_chk = 0;
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  seg7_scan_driver #(.NUM_DIGITS(8), .PRESCALE(4), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp(dp), .blank(blank),
    .busy(busy), .ack(ack), .frame_start(frame_start), .digit_idx(digit_idx),
    .an(an), .seg(seg), .dp_n(dp_n)
  );
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_req(input int m);
    load = 1'b0;
    busy_chk = 0;
    foreach (req_q[i]) if (req_q[i].at == m) begin
      value = req_q[i].f.v;
      dp = req_q[i].f.d;
      blank = req_q[i].f.b;
      load = 1'b1;
      if (exp_q.size() == 0) begin
        exp_q.push_back(req_q[i].f);
        busy_chk = 1;
      end
    end
  endtask
  task automatic run_frame(input string nm);
    int w = 0;
    int j, cix;
    bit ea;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic [2:0] e_idx;
    while (frame_start !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    total++; if (frame_start !== 1'b1) $display("FAIL %s frame_start timeout got %b exp 1", nm, frame_start); else passed++;
    ea = exp_q.size() > 0;
    total++; if (ack !== ea) $display("FAIL %s ack_at_wrap got %b exp %b", nm, ack, ea); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s busy_at_wrap got %b exp 0", nm, busy); else passed++;
    if (ea) disp = exp_q.pop_front();
    drive_req(0);
    for (int m = 1; m <= 32; m++) begin
      tick();
      if (busy_chk) begin
        total++; if (busy !== 1'b1) $display("FAIL %s busy_after_load m=%0d got %b exp 1", nm, m, busy); else passed++;
      end
      if (m < 32) drive_req(m);
      else begin
        load = 1'b0;
        busy_chk = 0;
      end
      j = m - 1;
      cix = (j / 4) % 8;
      e_an = (j % 4 == 0 || disp.b[cix]) ? 8'hFF : ~(8'h01 << cix);
      e_seg = dec[disp.v[cix*4 +: 4]];
      e_idx = 3'((m / 4) % 8);
      total++; if (an !== e_an) $display("FAIL %s an m=%0d got %h exp %h", nm, m, an, e_an); else passed++;
      total++; if (seg !== e_seg) $display("FAIL %s seg m=%0d got %h exp %h", nm, m, seg, e_seg); else passed++;
      total++; if (dp_n !== ~disp.d[cix]) $display("FAIL %s dp_n m=%0d got %b exp %b", nm, m, dp_n, ~disp.d[cix]); else passed++;
      total++; if (digit_idx !== e_idx) $display("FAIL %s digit_idx m=%0d got %0d exp %0d", nm, m, digit_idx, e_idx); else passed++;
      total++; if (frame_start !== (m == 32)) $display("FAIL %s frame_start m=%0d got %b exp %b", nm, m, frame_start, m == 32); else passed++;
      if (m < 32) begin
        total++; if (ack !== 1'b0) $display("FAIL %s ack_mid m=%0d got %b exp 0", nm, m, ack); else passed++;
      end
    end
    req_q.delete();
  endtask
  task automatic test_reset();
    logic [7:0] e_an;
    rst_n = 1'b0;
    load = 1'b1;
    value = 32'hFFFFFFFF;
    repeat (3) tick();
    total++; if (an !== 8'hFF) $display("FAIL rst_an got %h exp ff", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL rst_seg got %h exp 7f", seg); else passed++;
    total++; if (dp_n !== 1'b1) $display("FAIL rst_dp_n got %b exp 1", dp_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
    total++; if (ack !== 1'b0) $display("FAIL rst_ack got %b exp 0", ack); else passed++;
    total++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start got %b exp 0", frame_start); else passed++;
    total++; if (digit_idx !== 3'd0) $display("FAIL rst_digit_idx got %0d exp 0", digit_idx); else passed++;
    load = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      e_an = ((c - 1) % 4 == 0) ? 8'hFF : ~(8'h01 << (((c - 1) / 4) % 8));
      total++; if (digit_idx !== 3'((c / 4) % 8)) $display("FAIL scan_idx c=%0d got %0d exp %0d", c, digit_idx, (c / 4) % 8); else passed++;
      total++; if (frame_start !== (c % 32 == 0)) $display("FAIL scan_fs c=%0d got %b exp %b", c, frame_start, c % 32 == 0); else passed++;
      total++; if (an !== e_an) $display("FAIL scan_an c=%0d got %h exp %h", c, an, e_an); else passed++;
      total++; if (busy !== 1'b0 || ack !== 1'b0) $display("FAIL scan_idle c=%0d got busy=%b ack=%b exp 0 0", c, busy, ack); else passed++;
    end
  endtask
  task automatic test_scan_guard();
    run_frame("guard_idle");
  endtask
  task automatic test_commit();
    req_q.push_back('{5, '{32'h76543210, 8'h00, 8'h00}});
    run_frame("commit_stage");
    run_frame("commit_show");
  endtask
  task automatic test_back_to_back();
    req_q.push_back('{3, '{32'h89ABCDEF, 8'h00, 8'h00}});
    req_q.push_back('{10, '{32'hFFFFFFFF, 8'hFF, 8'h00}});
    req_q.push_back('{31, '{32'hFFFFFFFF, 8'hFF, 8'h00}});
    run_frame("busy_ignore");
    req_q.push_back('{0, '{32'h0F1E2D3C, 8'h55, 8'h00}});
    run_frame("ack_cycle_load");
    run_frame("ack_cycle_show");
  endtask
  task automatic test_blank_dp();
    req_q.push_back('{2, '{32'h12345678, 8'h01, 8'h80}});
    run_frame("bd_stage");
    run_frame("bd_show");
    run_frame("bd_idle");
  endtask
  task automatic test_async_reset();
    req_q.push_back('{5, '{32'hEEEEEEEE, 8'hFF, 8'h00}});
    drive_req(0);
    for (int m = 1; m <= 8; m++) begin
      tick();
      if (busy_chk) begin
        total++; if (busy !== 1'b1) $display("FAIL arst_busy_pre got %b exp 1", busy); else passed++;
      end
      drive_req(m);
    end
    load = 1'b0;
    req_q.delete();
    exp_q.delete();
    disp = '{32'h0, 8'h0, 8'h0};
    #2 rst_n = 1'b0;
    #1;
    total++; if (an !== 8'hFF) $display("FAIL arst_an got %h exp ff", an); else passed++;
    total++; if (seg !== 7'h7F) $display("FAIL arst_seg got %h exp 7f", seg); else passed++;
    total++; if (dp_n !== 1'b1) $display("FAIL arst_dp_n got %b exp 1", dp_n); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL arst_busy got %b exp 0", busy); else passed++;
    total++; if (ack !== 1'b0) $display("FAIL arst_ack got %b exp 0", ack); else passed++;
    tick();
    tick();
    total++; if (an !== 8'hFF || ack !== 1'b0) $display("FAIL arst_hold got an=%h ack=%b exp ff 0", an, ack); else passed++;
    @(negedge clk) rst_n = 1'b1;
    run_frame("arst_first");
    run_frame("arst_second");
  endtask
  initial begin
    test_reset();
    test_scan_guard();
    test_commit();
    test_back_to_back();
    test_blank_dp();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
